// File: rtl/psram_pkg.sv
// Shared definitions for the QPI PSRAM behavioural model: transaction states,
// command opcodes and phase lengths.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_READ   = 3'd4,
        ST_IGNORE = 3'd5
    } state_e;

    localparam logic [7:0] CMD_QWRITE    = 8'h38;
    localparam logic [7:0] CMD_QREAD     = 8'hEB;
    localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
    localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

    localparam int ADDR_NIBBLES    = 6;
    localparam int CMD_BITS_SPI    = 8;
    localparam int CMD_NIBBLES_QPI = 2;

    // Only the two data commands carry an address phase.
    function automatic logic is_addr_cmd(input logic [7:0] cmd);
        return (cmd == CMD_QWRITE) || (cmd == CMD_QREAD);
    endfunction

endpackage

// File: rtl/psram_qpi_model_mem.sv
// Byte array behind the PSRAM model: one synchronous write port and one
// asynchronous read port, depth 2^ADDR_W. Contents survive reset.
module psram_mem #(
    parameter int ADDR_W = 22
) (
    input  logic              sck_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge sck_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/psram_qpi_model.sv
// QPI PSRAM slave model: 0x38 quad write and 0xEB quad read bursts.
// Define PSRAM_QPI_MODE_EN to enable QPI command mode (0x35 enter / 0xF5 exit).
//
// state  | meaning
// CMD    | shifting in the command (8 serial bits, or 2 nibbles in QPI mode)
// ADDR   | shifting in 6 address nibbles, MSB nibble first
// WAIT   | READ_WAIT dummy cycles before read data, bus released
// WRITE  | nibble pairs committed to memory, address auto-increments
// READ   | nibble pairs driven on dio, address auto-increments
// IGNORE | unsupported or mode command, idle until ce_n rises
module psram_qpi_model
    import psram_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int READ_WAIT = 0
) (
    input  logic       sck,
    input  logic       rst_n,
    input  logic       ce_n,
    inout  wire  [3:0] dio
);

    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          hi_q, hi_d;
    logic                nib_q, nib_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic                qpi_mode;
    logic [3:0]          din;
    logic [7:0]          cmd_shift;
    logic                cmd_done;
    logic                addr_done;
    logic                wait_done;

    logic                mem_we;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic                oe_d, oe_q;
    logic [3:0]          dout_d, dout_q;

    assign din       = dio;
    assign cmd_shift = qpi_mode ? {cmd_q[3:0], din} : {cmd_q[6:0], din[0]};
    assign cmd_done  = (state_q == ST_CMD) &&
                       (cnt_q == (qpi_mode ? 3'(CMD_NIBBLES_QPI - 1) : 3'(CMD_BITS_SPI - 1)));
    assign addr_done = (state_q == ST_ADDR) && (cnt_q == 3'(ADDR_NIBBLES - 1));
    assign wait_done = (wait_q == '0);

    // ce_n high is a transaction-level reset; it must not touch qpi_mode.
    always_ff @(posedge sck or negedge rst_n or posedge ce_n) begin
        if (!rst_n || ce_n) begin
            state_q <= ST_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CMD: begin
                if (cmd_done) begin
                    state_d = is_addr_cmd(cmd_shift) ? ST_ADDR : ST_IGNORE;
                end
            end
            ST_ADDR: begin
                if (addr_done) begin
                    if (cmd_q == CMD_QWRITE) begin
                        state_d = ST_WRITE;
                    end else if (READ_WAIT > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE, ST_READ, ST_IGNORE: state_d = state_q;
            default: state_d = ST_CMD;
        endcase
    end

    always_comb begin
        mem_we    = (state_q == ST_WRITE) && nib_q;
        mem_wdata = {hi_q, din};
        oe_d      = (state_q == ST_READ);
        dout_d    = nib_q ? mem_rdata[3:0] : mem_rdata[7:4];
    end

    always_ff @(posedge sck or negedge rst_n or posedge ce_n) begin
        if (!rst_n || ce_n) begin
            cnt_q  <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
            hi_q   <= '0;
            nib_q  <= 1'b0;
            wait_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            hi_q   <= hi_d;
            nib_q  <= nib_d;
            wait_q <= wait_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        cmd_d  = cmd_q;
        addr_d = addr_q;
        hi_d   = hi_q;
        nib_d  = nib_q;
        wait_d = wait_q;
        case (state_q)
            ST_CMD: begin
                cmd_d = cmd_shift;
                cnt_d = cmd_done ? 3'd0 : cnt_q + 3'd1;
            end
            ST_ADDR: begin
                // Upper address bits beyond ADDR_W fall off the top of the shift.
                addr_d = (addr_q << 4) | ADDR_W'(din);
                cnt_d  = addr_done ? 3'd0 : cnt_q + 3'd1;
                if (addr_done) begin
                    wait_d = WAIT_W'(READ_WAIT - 1);
                end
            end
            ST_WAIT: begin
                if (!wait_done) begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_WRITE: begin
                nib_d = ~nib_q;
                if (!nib_q) begin
                    hi_d = din;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_READ: begin
                nib_d = ~nib_q;
                if (nib_q) begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

`ifdef PSRAM_QPI_MODE_EN
    logic qpi_q;

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            qpi_q <= 1'b0;
        end else if (cmd_done && (cmd_shift == CMD_QPI_ENTER)) begin
            qpi_q <= 1'b1;
        end else if (cmd_done && (cmd_shift == CMD_QPI_EXIT)) begin
            qpi_q <= 1'b0;
        end
    end

    assign qpi_mode = qpi_q;
`else
    assign qpi_mode = 1'b0;
`endif

    // Read nibbles launch on the falling edge so they are stable for the master's rising edge.
    always_ff @(negedge sck or negedge rst_n or posedge ce_n) begin
        if (!rst_n || ce_n) begin
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            oe_q   <= oe_d;
            dout_q <= dout_d;
        end
    end

    assign dio = oe_q ? dout_q : 4'bzzzz;

    psram_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .sck_i   (sck),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (mem_wdata),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

endmodule
